// File: rtl/gshare_branch_predictor_pkg.sv
// Shared encodings and helpers for the gshare direction predictor.
package gshare_branch_predictor_pkg;

    // 2-bit saturating counter encodings
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Record FSM: whether a predicted branch is waiting for its EX outcome
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } rec_state_t;

    // Move a 2-bit counter one step toward the observed outcome, saturating at both ends
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : cnt + 2'd1;
        end
        return (cnt == SNT) ? SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/gshare_branch_predictor_pht_sat_table.sv
// Pattern history table: 2^IDX_W two-bit saturating counters,
// one combinational read port and one synchronous update port.
module pht_sat_table
    import gshare_branch_predictor_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] cnt [DEPTH];

    // Direction bit of the addressed counter; reads registered state only
    assign rd_pred = cnt[rd_idx][1];

    // Counter update on resolve; every entry returns to weakly not-taken on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= WNT;
            end
        end else if (upd_en) begin
            cnt[upd_idx] <= sat_update(cnt[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: predicts ID branches, checks the prediction
// against the EX outcome one cycle later, flushes on mispredict and keeps
// saturating branch / mispredict counters.
module gshare_branch_predictor #(
    parameter int ADDR_W = 30,
    parameter int IDX_W  = 4,
    parameter int HIST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              id_branch,
    input  logic [ADDR_W-1:0] id_pc,
    output logic              pred_taken,
    input  logic              ex_resolve,
    input  logic              ex_taken,
    output logic              flush,
    // Branch-type strobe for the performance checker; "type" is a reserved word
    output logic              branch_type,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    import gshare_branch_predictor_pkg::*;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [HIST_W-1:0] ghr;
    logic [HIST_W:0]   ghr_shift;
    logic [IDX_W-1:0]  idx;
    logic              idx_pred;
    rec_state_t        state;
    logic [IDX_W-1:0]  rec_idx;
    logic              rec_pred;
    logic              capture;
    logic              resolve;
    logic              update;
    logic              unused_pc_hi;

    // Only the low PC bits take part in indexing
    assign unused_pc_hi = ^id_pc[ADDR_W-1:IDX_W];

    // History is zero-extended and folded into the low index bits
    assign idx = id_pc[IDX_W-1:0] ^ IDX_W'(ghr);

    assign pred_taken  = id_branch & idx_pred;
    assign branch_type = ex_resolve;

    // With nothing recorded, a resolve is judged against an implied not-taken
    assign flush = ex_resolve & ((state == PENDING) ? (ex_taken != rec_pred) : ex_taken);

    // A branch seen while flushing is on the wrong path and is dropped
    assign capture = id_branch & ~stall & ~flush;
    assign resolve = ex_resolve & ~stall;
    assign update  = resolve & (state == PENDING);

    // Shift-in built one bit wider so HIST_W = 1 needs no special case
    assign ghr_shift = {ghr, ex_taken};

    pht_sat_table #(
        .IDX_W(IDX_W)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_pred  (idx_pred),
        .upd_en   (update),
        .upd_idx  (rec_idx),
        .upd_taken(ex_taken)
    );

    // Record FSM: remember the prediction until EX resolves it; a new capture wins over a resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rec_idx  <= '0;
            rec_pred <= 1'b0;
        end else if (capture) begin
            state    <= PENDING;
            rec_idx  <= idx;
            rec_pred <= idx_pred;
        end else if (resolve) begin
            state    <= IDLE;
        end
    end

    // Global history advances only with real, recorded outcomes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr <= '0;
        end else if (update) begin
            ghr <= ghr_shift[HIST_W-1:0];
        end
    end

    // Saturating performance counters, bumped once per non-stalled resolve
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else if (resolve) begin
            branch_cnt <= sat_inc(branch_cnt);
            if (flush) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Testbench for gshare_branch_predictor: directed vector tables plus
// randomized traffic against a behavioural model.
module tb_gshare_branch_predictor;

    localparam int ADDR_W = 30;
    localparam int IDX_W  = 4;
    localparam int HIST_W = 4;
    localparam int CNT_W  = 16;
    localparam int NENT   = 1 << IDX_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall = 1'b0;
    logic              id_branch = 1'b0;
    logic [ADDR_W-1:0] id_pc = '0;
    logic              pred_taken;
    logic              ex_resolve = 1'b0;
    logic              ex_taken = 1'b0;
    logic              flush;
    logic              branch_type;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gshare_branch_predictor #(
        .ADDR_W(ADDR_W),
        .IDX_W (IDX_W),
        .HIST_W(HIST_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .id_branch  (id_branch),
        .id_pc      (id_pc),
        .pred_taken (pred_taken),
        .ex_resolve (ex_resolve),
        .ex_taken   (ex_taken),
        .flush      (flush),
        .branch_type(branch_type),
        .branch_cnt (branch_cnt),
        .miss_cnt   (miss_cnt)
    );

    // One cycle of stimulus with the outputs expected before the clock edge
    typedef struct {
        int s;  int b;  int pc; int r;  int t;
        int ep; int ef; int et; int bc; int mc;
    } vec_t;

    function automatic vec_t mk(int s, int b, int pc, int r, int t,
                                int ep, int ef, int et, int bc, int mc);
        vec_t v;
        v.s = s; v.b = b; v.pc = pc; v.r = r; v.t = t;
        v.ep = ep; v.ef = ef; v.et = et; v.bc = bc; v.mc = mc;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        stall      = (v.s != 0);
        id_branch  = (v.b != 0);
        id_pc      = ADDR_W'(v.pc);
        ex_resolve = (v.r != 0);
        ex_taken   = (v.t != 0);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        check({tag, ".pred"},  int'(pred_taken),  v.ep);
        check({tag, ".flush"}, int'(flush),       v.ef);
        check({tag, ".type"},  int'(branch_type), v.et);
        check({tag, ".bcnt"},  int'(branch_cnt),  v.bc);
        check({tag, ".mcnt"},  int'(miss_cnt),    v.mc);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check({tag, ".rst_pred"},  int'(pred_taken),  0);
        check({tag, ".rst_flush"}, int'(flush),       0);
        check({tag, ".rst_type"},  int'(branch_type), 0);
        check({tag, ".rst_bcnt"},  int'(branch_cnt),  0);
        check({tag, ".rst_mcnt"},  int'(miss_cnt),    0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Behavioural model: counters held as small integers 0..3
    int m_pht [NENT];
    int m_ghr, m_pend, m_ridx, m_rpred, m_bc, m_mc;

    function automatic void model_reset();
        for (int i = 0; i < NENT; i++) m_pht[i] = 1;
        m_ghr = 0; m_pend = 0; m_ridx = 0; m_rpred = 0; m_bc = 0; m_mc = 0;
    endfunction

    // Produces the expected outputs for this cycle, then advances the model past the edge
    function automatic vec_t model_cycle(input int s, b, pc, r, t);
        int idx, pbit, ef, cap;
        vec_t v;
        idx  = (pc % NENT) ^ m_ghr;
        pbit = (m_pht[idx] >= 2) ? 1 : 0;
        ef   = 0;
        if (r != 0) ef = (m_pend != 0) ? ((t != m_rpred) ? 1 : 0) : t;
        v = mk(s, b, pc, r, t, (b != 0) ? pbit : 0, ef, r, m_bc, m_mc);
        if (s == 0) begin
            cap = (b != 0 && ef == 0) ? 1 : 0;
            if (r != 0) begin
                if (m_bc < CMAX) m_bc++;
                if (ef != 0 && m_mc < CMAX) m_mc++;
                if (m_pend != 0) begin
                    if (t != 0) m_pht[m_ridx] = (m_pht[m_ridx] < 3) ? m_pht[m_ridx] + 1 : 3;
                    else        m_pht[m_ridx] = (m_pht[m_ridx] > 0) ? m_pht[m_ridx] - 1 : 0;
                    m_ghr = (m_ghr * 2 + t) % (1 << HIST_W);
                end
            end
            if (cap != 0) begin
                m_pend = 1; m_ridx = idx; m_rpred = pbit;
            end else if (r != 0) begin
                m_pend = 0;
            end
        end
        return v;
    endfunction

    vec_t tbl[$];
    vec_t seq[$];

    initial begin
        // Directed table, starting from reset (GHR = 0, all entries 01)
        //                 s  b  pc r  t   ep ef et bc  mc
        tbl.push_back(mk(0, 1,  5, 0, 0,  0, 0, 0, 0, 0));  // capture idx 5
        tbl.push_back(mk(0, 0,  0, 1, 0,  0, 0, 1, 0, 0));  // correct NT, 5: 01->00
        tbl.push_back(mk(0, 0,  0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1,  5, 0, 0,  0, 0, 0, 1, 0));  // capture idx 5
        tbl.push_back(mk(0, 1,  3, 1, 1,  0, 1, 1, 1, 0));  // mispredict, ID branch dropped
        tbl.push_back(mk(0, 0,  0, 1, 0,  0, 0, 1, 2, 1));  // resolve while IDLE, no write
        tbl.push_back(mk(0, 1,  4, 0, 0,  0, 0, 0, 3, 1));  // 4^1 = idx 5 still 01
        tbl.push_back(mk(0, 0,  0, 1, 1,  0, 1, 1, 3, 1));  // 5: 01->10, ghr 3
        tbl.push_back(mk(0, 1,  6, 0, 0,  1, 0, 0, 4, 2));  // 6^3 = 5 reads 10
        tbl.push_back(mk(0, 0,  0, 1, 1,  0, 0, 1, 4, 2));  // 5: 10->11, ghr 7
        tbl.push_back(mk(0, 0,  0, 1, 1,  0, 1, 1, 5, 2));  // IDLE resolve taken flushes
        tbl.push_back(mk(0, 1,  2, 0, 0,  1, 0, 0, 6, 3));  // 2^7 = 5 reads 11
        tbl.push_back(mk(1, 0,  0, 1, 0,  0, 1, 1, 6, 3));  // stalled mismatch held
        tbl.push_back(mk(1, 0,  0, 1, 0,  0, 1, 1, 6, 3));
        tbl.push_back(mk(1, 0,  0, 1, 0,  0, 1, 1, 6, 3));
        tbl.push_back(mk(0, 0,  0, 1, 0,  0, 1, 1, 6, 3));  // 5: 11->10, ghr 14
        tbl.push_back(mk(1, 1, 11, 0, 0,  1, 0, 0, 7, 4));  // stalled ID branch, no capture
        tbl.push_back(mk(0, 0,  0, 1, 0,  0, 0, 1, 7, 4));  // still IDLE
        tbl.push_back(mk(0, 1, 11, 0, 0,  1, 0, 0, 8, 4));  // capture idx 5, pred 1
        tbl.push_back(mk(0, 1, 11, 1, 1,  1, 0, 1, 8, 4));  // resolve + capture same idx
        tbl.push_back(mk(0, 0,  0, 1, 1,  0, 0, 1, 9, 4));  // still PENDING, pred 1
        tbl.push_back(mk(0, 0,  0, 0, 0,  0, 0, 0, 10, 4));
        tbl.push_back(mk(0, 0, 14, 0, 0,  0, 0, 0, 10, 4)); // no id_branch, no prediction

        // Same entry (idx 9) trained taken three times, then once not-taken
        seq.push_back(mk(0, 1,  9, 0, 0,  0, 0, 0, 0, 0));
        seq.push_back(mk(0, 0,  0, 1, 1,  0, 1, 1, 0, 0));  // 01->10, ghr 1
        seq.push_back(mk(0, 1,  8, 0, 0,  1, 0, 0, 1, 1));
        seq.push_back(mk(0, 0,  0, 1, 1,  0, 0, 1, 1, 1));  // 10->11, ghr 3
        seq.push_back(mk(0, 1, 10, 0, 0,  1, 0, 0, 2, 1));
        seq.push_back(mk(0, 0,  0, 1, 1,  0, 0, 1, 2, 1));  // 11 stays, ghr 7
        seq.push_back(mk(0, 1, 14, 0, 0,  1, 0, 0, 3, 1));
        seq.push_back(mk(0, 0,  0, 1, 0,  0, 1, 1, 3, 1));  // 11->10, ghr 14
        seq.push_back(mk(0, 1,  7, 0, 0,  1, 0, 0, 4, 2));  // 7^14 = 9 reads 10, now PENDING

        rst = 1'b0;
        repeat (2) @(posedge clk);

        do_reset("tbl");
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        do_reset("seq");
        for (int i = 0; i < seq.size(); i++) apply(seq[i], $sformatf("seq[%0d]", i));

        // Asynchronous reset while PENDING with pred 1: resolve NT must not flush
        @(negedge clk);
        rst = 1'b0;
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        #1;
        check("arst.flush", int'(flush),       0);
        check("arst.type",  int'(branch_type), 1);
        check("arst.bcnt",  int'(branch_cnt),  0);
        check("arst.mcnt",  int'(miss_cnt),    0);
        for (int pc = 0; pc < NENT; pc++) begin
            drive(mk(0, 1, pc, 0, 0, 0, 0, 0, 0, 0));
            #1;
            check($sformatf("arst.pred[%0d]", pc), int'(pred_taken), 0);
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        apply(mk(0, 1, 9, 0, 0, 0, 0, 0, 0, 0), "arst.after");

        // Counter saturation: resolve-taken while IDLE mispredicts every cycle
        do_reset("sat");
        for (int i = 0; i <= CMAX + 2; i++) begin
            @(negedge clk);
            drive(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
            #1;
            if (i == CMAX - 1) begin
                check("sat.bcnt_pre", int'(branch_cnt), CMAX - 1);
                check("sat.mcnt_pre", int'(miss_cnt),   CMAX - 1);
            end
            if (i == CMAX) begin
                check("sat.bcnt_max", int'(branch_cnt), CMAX);
                check("sat.mcnt_max", int'(miss_cnt),   CMAX);
            end
            if (i == CMAX + 2) begin
                check("sat.bcnt_hold", int'(branch_cnt), CMAX);
                check("sat.mcnt_hold", int'(miss_cnt),   CMAX);
            end
        end

        // Randomized traffic against the model
        do_reset("rnd");
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            int s, b, pc, r, t;
            s  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            b  = int'($urandom_range(0, 1));
            pc = int'($urandom() & 32'h3FFF_FFFF);
            r  = ($urandom_range(0, 9) < 6) ? 1 : 0;
            t  = int'($urandom_range(0, 1));
            apply(model_cycle(s, b, pc, r, t), $sformatf("rnd[%0d]", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
